// File: rtl/swap_sequenciador_if.sv
// Request/handshake bundle between the swap command sequencer (master) and its system/swap-unit side (slave).
interface swap_sequenciador_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int PW = $clog2(DEPTH + 1);

    logic             req_valid;
    logic             req_ready;
    logic             done;
    logic             w;
    logic             busy;
    logic [PW-1:0]    pending;
    logic [CNT_W-1:0] swap_count;
    logic             err;
    logic             err_clr;

    modport master (
        input  req_valid,
        input  done,
        input  err_clr,
        output req_ready,
        output w,
        output busy,
        output pending,
        output swap_count,
        output err
    );

    modport slave (
        output req_valid,
        output done,
        output err_clr,
        input  req_ready,
        input  w,
        input  busy,
        input  pending,
        input  swap_count,
        input  err
    );
endinterface

// File: rtl/swap_sequenciador.sv
// Queues swap requests and issues them one at a time on w, waiting for done between swaps.
// Optional WAIT timeout with sticky err is enabled by defining SWAP_TIMEOUT_EN.
module swap_sequenciador #(
    parameter int DEPTH          = 4,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                ck,
    input  logic                rst,
    swap_sequenciador_if.master bus
);
    localparam int            PW      = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic             w_q, w_d;
    logic [PW-1:0]    pending_q, pending_d;
    logic [CNT_W-1:0] swap_count_q, swap_count_d;
    logic             req_ready;
    logic             accept;
    logic             complete;
    logic             abort;
    logic             timeout_hit;
    logic             err_q;

    // No bypass: a completion this cycle only frees a slot from the next cycle on.
    assign req_ready = (pending_q < DEPTH_V);
    assign accept    = bus.req_valid & req_ready;

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done must be seen low before a new swap is started
                if ((pending_q != '0) && !bus.done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.done) begin
                    complete = 1'b1;
                    state_d  = S_RELEASE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bus.done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        w_d = (state_d == S_WAIT);
    end

    always_comb begin
        pending_d = pending_q;
        case ({accept, complete | abort})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
        swap_count_d = complete ? (swap_count_q + CNT_W'(1)) : swap_count_q;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            w_q          <= 1'b0;
            pending_q    <= '0;
            swap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            pending_q    <= pending_d;
            swap_count_q <= swap_count_d;
        end
    end

`ifdef SWAP_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_d;

    // Counter restarts on every WAIT entry and counts cycles spent in WAIT.
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == TO_LAST);

    always_comb begin
        wait_cnt_d = '0;
        if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            wait_cnt_d = wait_cnt_q + TW'(1);
        end
        err_d = err_q;
        if (abort) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic          unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign timeout_hit    = 1'b0;
    assign err_q          = 1'b0;
`endif

    assign bus.req_ready  = req_ready;
    assign bus.w          = w_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.pending    = pending_q;
    assign bus.swap_count = swap_count_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_swap_sequenciador.sv
// Directed + randomized bench for swap_sequenciador against a cycle-level reference model of the sequencing rules.
module tb_swap_sequenciador;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int TO    = 16;
    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_REL  = 2;

    logic ck = 1'b0;
    logic rst;
    always #5 ck = ~ck;

    swap_sequenciador_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

    swap_sequenciador #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .ck (ck),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_pending;
    int m_phase;
    int m_wcnt;
    int m_count;
    int m_err;
    int w_rises;
    int w_high;
    logic w_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0;
        m_phase   = PH_IDLE;
        m_wcnt    = 0;
        m_count   = 0;
        m_err     = 0;
        w_prev    = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".w"},          32'(bus.w),          32'(m_phase == PH_WAIT));
        check({ctx, ".busy"},       32'(bus.busy),       32'(m_phase != PH_IDLE));
        check({ctx, ".pending"},    32'(bus.pending),    32'(m_pending));
        check({ctx, ".swap_count"}, 32'(bus.swap_count), 32'(m_count));
        check({ctx, ".req_ready"},  32'(bus.req_ready),  32'(m_pending < DEPTH));
        check({ctx, ".err"},        32'(bus.err),        32'(m_err));
    endtask

    // One clock: apply the rules to the inputs seen at the edge, then compare.
    task automatic tick(input string ctx);
        bit rv, dn, ec, acc, fin, ab;
        rv  = bus.req_valid;
        dn  = bus.done;
        ec  = bus.err_clr;
        acc = rv && (m_pending < DEPTH);
        fin = 1'b0;
        ab  = 1'b0;
        @(posedge ck);
        #1;
        if (m_phase == PH_IDLE) begin
            if (m_pending != 0 && !dn) begin
                m_phase = PH_WAIT;
                m_wcnt  = 0;
            end
        end else if (m_phase == PH_WAIT) begin
            if (dn) begin
                fin = 1'b1;
                m_phase = PH_REL;
            end else begin
`ifdef SWAP_TIMEOUT_EN
                if (m_wcnt == TO - 1) begin
                    ab = 1'b1;
                    m_phase = PH_REL;
                end else begin
                    m_wcnt++;
                end
`endif
            end
        end else begin
            if (!dn) m_phase = PH_IDLE;
        end
        m_pending = m_pending + int'(acc) - int'(fin | ab);
        m_count   = (m_count + int'(fin)) % (1 << CNT_W);
`ifdef SWAP_TIMEOUT_EN
        if (ab) m_err = 1;
        else if (ec) m_err = 0;
`endif
        if (bus.w === 1'b1 && w_prev !== 1'b1) w_rises++;
        if (bus.w === 1'b1) w_high++;
        w_prev = bus.w;
        check_all(ctx);
    endtask

    initial begin
        int r0, h0, c0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.done      = 1'b0;
        bus.err_clr   = 1'b0;
        w_rises       = 0;
        w_high        = 0;
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        check_all("reset");
        rst = 1'b0;

        // T2: single swap, done returned after w has been high 3 cycles
        h0 = w_high;
        bus.req_valid = 1'b1;
        tick("t2_acc");
        bus.req_valid = 1'b0;
        check("t2_pending_after_accept", 32'(bus.pending), 32'd1);
        check("t2_w_not_yet", 32'(bus.w), 32'd0);
        tick("t2_issue");
        check("t2_w_rise", 32'(bus.w), 32'd1);
        tick("t2_hold1");
        tick("t2_hold2");
        bus.done = 1'b1;
        tick("t2_done");
        check("t2_count", 32'(bus.swap_count), 32'd1);
        check("t2_w_high_cycles", 32'(w_high - h0), 32'd3);
        bus.done = 1'b0;
        tick("t2_release");
        check("t2_idle", 32'(bus.busy), 32'd0);

        // T3: fill with done never rising
        r0 = w_rises;
        bus.req_valid = 1'b1;
        repeat (6) tick("t3_fill");
        check("t3_pending_full", 32'(bus.pending), 32'(DEPTH));
        check("t3_ready_low", 32'(bus.req_ready), 32'd0);
        check("t3_one_w", 32'(w_rises - r0), 32'd1);

        // T4: completion while full and req_valid held
        bus.done = 1'b1;
        tick("t4_complete");
        check("t4_pending_dec", 32'(bus.pending), 32'(DEPTH - 1));
        check("t4_ready_high", 32'(bus.req_ready), 32'd1);
        tick("t4_refill");
        check("t4_pending_refull", 32'(bus.pending), 32'(DEPTH));
        bus.req_valid = 1'b0;
        bus.done      = 1'b0;

        // Drain using a responder that echoes w on done
        for (int i = 0; i < 200 && m_pending != 0; i++) begin
            bus.done = bus.w;
            tick("drain");
        end
        bus.done = 1'b0;
        check("drain_empty", 32'(bus.pending), 32'd0);
        tick("drain_idle1");
        tick("drain_idle2");

        // T5: done stuck high in IDLE blocks issue
        bus.done      = 1'b1;
        bus.req_valid = 1'b1;
        tick("t5_acc");
        bus.req_valid = 1'b0;
        repeat (4) tick("t5_stuck");
        check("t5_w_blocked", 32'(bus.w), 32'd0);
        bus.done = 1'b0;
        tick("t5_released");
        check("t5_w_issued", 32'(bus.w), 32'd1);
        bus.done = 1'b1;
        tick("t5_done");
        bus.done = 1'b0;
        tick("t5_idle");

`ifdef SWAP_TIMEOUT_EN
        // T6: timeout abort with sticky err
        c0 = m_count;
        h0 = w_high;
        bus.req_valid = 1'b1;
        tick("t6_acc");
        bus.req_valid = 1'b0;
        for (int i = 0; i < 40 && m_phase != PH_REL; i++) tick("t6_wait");
        check("t6_w_high_cycles", 32'(w_high - h0), 32'(TO));
        check("t6_err", 32'(bus.err), 32'd1);
        check("t6_count_kept", 32'(bus.swap_count), 32'(c0));
        tick("t6_idle");
        bus.err_clr = 1'b1;
        tick("t6_clr");
        bus.err_clr = 1'b0;
        check("t6_err_cleared", 32'(bus.err), 32'd0);
`else
        c0 = 0;
`endif

        // Randomized traffic including spurious done pulses and counter wrap
        for (int i = 0; i < 900; i++) begin
            bus.req_valid = ($urandom_range(0, 2) != 0);
            if (bus.w === 1'b1) bus.done = ($urandom_range(0, 2) == 0);
            else                bus.done = ($urandom_range(0, 4) == 0);
            bus.err_clr = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        bus.req_valid = 1'b0;
        bus.done      = 1'b0;
        bus.err_clr   = 1'b0;

        // T1: asynchronous reset in the middle of WAIT
        if (m_pending == 0) begin
            bus.req_valid = 1'b1;
            tick("t1_acc");
            bus.req_valid = 1'b0;
        end
        for (int i = 0; i < 10 && m_phase != PH_WAIT; i++) tick("t1_towait");
        check("t1_in_wait", 32'(bus.w), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t1_w", 32'(bus.w), 32'd0);
        check("t1_pending", 32'(bus.pending), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd0);
        check("t1_count", 32'(bus.swap_count), 32'd0);
        @(posedge ck);
        #1;
        rst = 1'b0;
        check_all("t1_after");
        tick("t1_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
